// File: rtl/umi_crossbar_nxn.sv
// N x N UMI crossbar: per-output arbiter with grant lock and masking,
// combinational AND-OR datapath, multicast when an input requests several outputs.
module umi_crossbar_nxn #(
    parameter int N  = 4,
    parameter int CW = 32,
    parameter int AW = 64,
    parameter int DW = 512
) (
    input  logic              clk,
    input  logic              nreset,
    input  logic [1:0]        mode,
    input  logic [N*N-1:0]    mask,
    input  logic [N*N-1:0]    umi_in_request,
    input  logic [N*CW-1:0]   umi_in_cmd,
    input  logic [N*AW-1:0]   umi_in_dstaddr,
    input  logic [N*AW-1:0]   umi_in_srcaddr,
    input  logic [N*DW-1:0]   umi_in_data,
    output logic [N-1:0]      umi_in_ready,
    output logic [N-1:0]      umi_out_valid,
    output logic [N*CW-1:0]   umi_out_cmd,
    output logic [N*AW-1:0]   umi_out_dstaddr,
    output logic [N*AW-1:0]   umi_out_srcaddr,
    output logic [N*DW-1:0]   umi_out_data,
    input  logic [N-1:0]      umi_out_ready
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0][N-1:0]  ereq;
    logic [N-1:0][N-1:0]  grant;
    logic [N-1:0][N-1:0]  lock_grant;
    logic [N-1:0]         lock;
    logic [N-1:0][PW-1:0] ptr;
    logic [N-1:0][PW-1:0] ptr_nxt;
    logic [N-1:0]         any_req;
    logic [N-1:0]         all_ok;
    logic                 rr;
    logic                 mode_unused;

    assign rr          = mode[1];
    assign mode_unused = mode[0];

    always_comb begin
        ereq = '0;
        for (int j = 0; j < N; j++) begin
            for (int i = 0; i < N; i++) begin
                ereq[j][i] = umi_in_request[j*N+i] & ~mask[j*N+i];
            end
        end
    end

    // A stalled grant is held while its request persists, ignoring newcomers.
    always_comb begin
        logic          found;
        logic [PW-1:0] sel;
        grant = '0;
        found = 1'b0;
        sel   = '0;
        for (int j = 0; j < N; j++) begin
            found = 1'b0;
            if (lock[j] && |(lock_grant[j] & ereq[j])) begin
                grant[j] = lock_grant[j];
            end else begin
                for (int k = 0; k < N; k++) begin
                    if (rr)
                        sel = PW'((int'(ptr[j]) + k) % N);
                    else
                        sel = PW'(k);
                    if (!found && ereq[j][sel]) begin
                        grant[j][sel] = 1'b1;
                        found         = 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        umi_out_valid   = '0;
        umi_out_cmd     = '0;
        umi_out_dstaddr = '0;
        umi_out_srcaddr = '0;
        umi_out_data    = '0;
        for (int j = 0; j < N; j++) begin
            umi_out_valid[j] = |(ereq[j] & grant[j]);
            for (int i = 0; i < N; i++) begin
                if (grant[j][i]) begin
                    umi_out_cmd[j*CW+:CW] =
                        umi_out_cmd[j*CW+:CW] | umi_in_cmd[i*CW+:CW];
                    umi_out_dstaddr[j*AW+:AW] =
                        umi_out_dstaddr[j*AW+:AW] | umi_in_dstaddr[i*AW+:AW];
                    umi_out_srcaddr[j*AW+:AW] =
                        umi_out_srcaddr[j*AW+:AW] | umi_in_srcaddr[i*AW+:AW];
                    umi_out_data[j*DW+:DW] =
                        umi_out_data[j*DW+:DW] | umi_in_data[i*DW+:DW];
                end
            end
        end
    end

    // Multicast inputs complete only when every requested output accepts.
    always_comb begin
        any_req      = '0;
        all_ok       = '1;
        umi_in_ready = '0;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                if (ereq[j][i]) begin
                    any_req[i] = 1'b1;
                    if (!(grant[j][i] && umi_out_ready[j]))
                        all_ok[i] = 1'b0;
                end
            end
            umi_in_ready[i] = any_req[i] & all_ok[i];
        end
    end

    always_comb begin
        ptr_nxt = ptr;
        for (int j = 0; j < N; j++) begin
            if (umi_out_valid[j] && umi_out_ready[j]) begin
                for (int i = 0; i < N; i++) begin
                    if (grant[j][i])
                        ptr_nxt[j] = PW'((i + 1) % N);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            ptr        <= '0;
            lock       <= '0;
            lock_grant <= '0;
        end else begin
            for (int j = 0; j < N; j++) begin
                ptr[j]        <= ptr_nxt[j];
                lock[j]       <= umi_out_valid[j] & ~umi_out_ready[j];
                lock_grant[j] <= grant[j];
            end
        end
    end

endmodule

// File: tb/tb_umi_crossbar_nxn.sv
// Directed bench for umi_crossbar_nxn with a handshake scoreboard.
module tb_umi_crossbar_nxn;

    localparam int N  = 4;
    localparam int CW = 32;
    localparam int AW = 64;
    localparam int DW = 512;

    logic            clk;
    logic            nreset;
    logic [1:0]      mode;
    logic [N*N-1:0]  mask;
    logic [N*N-1:0]  umi_in_request;
    logic [N*CW-1:0] umi_in_cmd;
    logic [N*AW-1:0] umi_in_dstaddr;
    logic [N*AW-1:0] umi_in_srcaddr;
    logic [N*DW-1:0] umi_in_data;
    logic [N-1:0]    umi_in_ready;
    logic [N-1:0]    umi_out_valid;
    logic [N*CW-1:0] umi_out_cmd;
    logic [N*AW-1:0] umi_out_dstaddr;
    logic [N*AW-1:0] umi_out_srcaddr;
    logic [N*DW-1:0] umi_out_data;
    logic [N-1:0]    umi_out_ready;

    umi_crossbar_nxn #(.N(N), .CW(CW), .AW(AW), .DW(DW)) dut (
        .clk             (clk),
        .nreset          (nreset),
        .mode            (mode),
        .mask            (mask),
        .umi_in_request  (umi_in_request),
        .umi_in_cmd      (umi_in_cmd),
        .umi_in_dstaddr  (umi_in_dstaddr),
        .umi_in_srcaddr  (umi_in_srcaddr),
        .umi_in_data     (umi_in_data),
        .umi_in_ready    (umi_in_ready),
        .umi_out_valid   (umi_out_valid),
        .umi_out_cmd     (umi_out_cmd),
        .umi_out_dstaddr (umi_out_dstaddr),
        .umi_out_srcaddr (umi_out_srcaddr),
        .umi_out_data    (umi_out_data),
        .umi_out_ready   (umi_out_ready)
    );

    typedef struct {
        int            port;
        logic [CW-1:0] cmd;
        logic [AW-1:0] dst;
        logic [AW-1:0] src;
        logic [DW-1:0] data;
    } item_t;

    item_t q[$];
    int    checks   = 0;
    int    failures = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [CW-1:0] pcmd(int i, int t);
        return CW'(32'hC000_0000 + i * 256 + t);
    endfunction

    function automatic logic [AW-1:0] pdst(int i, int t);
        return {32'hD570_0000 + 32'(i), 32'(t)};
    endfunction

    function automatic logic [AW-1:0] psrc(int i, int t);
        return {32'h5AC0_0000 + 32'(i), 32'(t) ^ 32'hFFFF_0000};
    endfunction

    function automatic logic [DW-1:0] pdata(int i, int t);
        logic [31:0] w;
        w = 32'hDA00_0000 + 32'(i * 256 + t);
        return {16{w}};
    endfunction

    task automatic cmp(string nm, logic [DW-1:0] act, logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    task automatic set_in(int i, int t);
        umi_in_cmd[i*CW+:CW]     = pcmd(i, t);
        umi_in_dstaddr[i*AW+:AW] = pdst(i, t);
        umi_in_srcaddr[i*AW+:AW] = psrc(i, t);
        umi_in_data[i*DW+:DW]    = pdata(i, t);
    endtask

    task automatic push(int j, int i, int t);
        item_t it;
        it.port = j;
        it.cmd  = pcmd(i, t);
        it.dst  = pdst(i, t);
        it.src  = psrc(i, t);
        it.data = pdata(i, t);
        q.push_back(it);
    endtask

    task automatic chk(string nm, logic [N-1:0] v, logic [N-1:0] r);
        @(negedge clk);
        cmp({nm, "_valid"}, DW'(umi_out_valid), DW'(v));
        cmp({nm, "_ready"}, DW'(umi_in_ready), DW'(r));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear();
        umi_in_request = '0;
        mask           = '0;
    endtask

    // Monitor: every output handshake must match the oldest expected item.
    initial begin
        item_t it;
        forever begin
            @(negedge clk);
            if (nreset) begin
                for (int j = 0; j < N; j++) begin
                    if (umi_out_valid[j] && umi_out_ready[j]) begin
                        if (q.size() == 0) begin
                            cmp("sb_unexpected", DW'(j + 1), DW'(0));
                        end else begin
                            it = q.pop_front();
                            cmp("sb_port", DW'(j), DW'(it.port));
                            cmp("sb_cmd", DW'(umi_out_cmd[j*CW+:CW]), DW'(it.cmd));
                            cmp("sb_dst", DW'(umi_out_dstaddr[j*AW+:AW]), DW'(it.dst));
                            cmp("sb_src", DW'(umi_out_srcaddr[j*AW+:AW]), DW'(it.src));
                            cmp("sb_data", umi_out_data[j*DW+:DW], it.data);
                        end
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        failures++;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        nreset         = 1'b0;
        mode           = 2'b00;
        mask           = '0;
        umi_in_request = '0;
        umi_in_cmd     = '0;
        umi_in_dstaddr = '0;
        umi_in_srcaddr = '0;
        umi_in_data    = '0;
        umi_out_ready  = '0;
        tick();
        chk("reset", 4'b0000, 4'b0000);
        cmp("reset_cmd", DW'(umi_out_cmd), DW'(0));
        cmp("reset_data", umi_out_data[DW-1:0], DW'(0));
        tick();
        nreset        = 1'b1;
        umi_out_ready = 4'hF;

        set_in(0, 1);
        umi_in_request[2*4+0] = 1'b1;
        push(2, 0, 1);
        chk("single", 4'b0100, 4'b0001);
        cmp("single_cmd", DW'(umi_out_cmd[2*CW+:CW]), DW'(pcmd(0, 1)));
        cmp("single_data", umi_out_data[2*DW+:DW], pdata(0, 1));
        tick();
        clear();

        mode = 2'b00;
        set_in(1, 2);
        set_in(3, 3);
        umi_in_request[0*4+1] = 1'b1;
        umi_in_request[0*4+3] = 1'b1;
        for (int c = 0; c < 3; c++) begin
            push(0, 1, 2);
            chk("fixed", 4'b0001, 4'b0010);
            tick();
        end
        clear();

        mode = 2'b10;
        for (int i = 0; i < N; i++) begin
            set_in(i, 10 + i);
            umi_in_request[1*4+i] = 1'b1;
        end
        for (int c = 0; c < 5; c++) begin
            push(1, c % 4, 10 + (c % 4));
            chk("rr", 4'b0010, 4'(1 << (c % 4)));
            tick();
        end
        clear();

        umi_out_ready = 4'b0111;
        set_in(2, 20);
        set_in(0, 21);
        umi_in_request[3*4+2] = 1'b1;
        chk("lock_grant", 4'b1000, 4'b0000);
        cmp("lock_grant_cmd", DW'(umi_out_cmd[3*CW+:CW]), DW'(pcmd(2, 20)));
        tick();
        umi_in_request[3*4+0] = 1'b1;
        for (int c = 0; c < 4; c++) begin
            chk("lock_hold", 4'b1000, 4'b0000);
            cmp("lock_hold_cmd", DW'(umi_out_cmd[3*CW+:CW]), DW'(pcmd(2, 20)));
            tick();
        end
        umi_out_ready = 4'hF;
        push(3, 2, 20);
        chk("lock_release", 4'b1000, 4'b0100);
        tick();
        umi_in_request[3*4+2] = 1'b0;
        push(3, 0, 21);
        chk("lock_next", 4'b1000, 4'b0001);
        tick();
        clear();

        mode = 2'b00;
        set_in(2, 30);
        mask[1*4+2]           = 1'b1;
        umi_in_request[1*4+2] = 1'b1;
        for (int c = 0; c < 2; c++) begin
            chk("mask", 4'b0000, 4'b0000);
            cmp("mask_cmd", DW'(umi_out_cmd[1*CW+:CW]), DW'(0));
            tick();
        end
        mask = '0;
        push(1, 2, 30);
        chk("unmask", 4'b0010, 4'b0100);
        tick();
        clear();

        set_in(1, 40);
        umi_in_request[0*4+1] = 1'b1;
        umi_in_request[2*4+1] = 1'b1;
        push(0, 1, 40);
        push(2, 1, 40);
        chk("mcast", 4'b0101, 4'b0010);
        tick();
        umi_out_ready = 4'b0000;
        chk("all_stall", 4'b0101, 4'b0000);
        tick();
        clear();
        umi_out_ready = 4'hF;
        chk("idle", 4'b0000, 4'b0000);
        tick();

        mode          = 2'b10;
        umi_out_ready = 4'b1101;
        set_in(3, 50);
        set_in(0, 51);
        umi_in_request[1*4+3] = 1'b1;
        umi_in_request[1*4+0] = 1'b1;
        chk("rst_pre", 4'b0010, 4'b0000);
        cmp("rst_pre_cmd", DW'(umi_out_cmd[1*CW+:CW]), DW'(pcmd(3, 50)));
        tick();
        nreset = 1'b0;
        chk("rst_mid", 4'b0010, 4'b0000);
        cmp("rst_mid_cmd", DW'(umi_out_cmd[1*CW+:CW]), DW'(pcmd(0, 51)));
        tick();
        nreset        = 1'b1;
        umi_out_ready = 4'hF;
        push(1, 0, 51);
        chk("rst_after", 4'b0010, 4'b0001);
        tick();
        clear();
        tick();

        cmp("sb_empty", DW'(q.size()), DW'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
